button_debounce: RTL and testbench



---
 rtl/button_debounce_if.sv | 9 +
 rtl/button_debounce.sv | 74 +++++++
 tb/tb_button_debounce.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/button_debounce_if.sv
// Button debounce interface: the raw button level in, the debounced press pulse out.
interface button_debounce_if;
  logic btn_in;
  logic btn_pressed;

  // The board or bench drives the button; the debouncer returns the press pulse.
  modport master (output btn_in, input btn_pressed);
  modport slave  (input btn_in, output btn_pressed);
endinterface

// File: rtl/button_debounce.sv
// Button debouncer: a synchronizer chain, then a stability window.
// A one-cycle pulse is emitted for each debounced press. Releases emit nothing.
//
// state       | meaning
// ------------+------------------------------------------------
// ST_RELEASED | debounced button level is 0 (not pressed)
// ST_PRESSED  | debounced button level is 1 (pressed and held)
module button_debounce #(
  parameter int STABLE_CYCLES = 100000,
  parameter int SYNC_STAGES   = 2
) (
  input logic               clk,
  input logic               rst_n,   // active-high asynchronous reset, despite the name
  button_debounce_if.slave  bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic {ST_RELEASED = 1'b0, ST_PRESSED = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   differs;
  state_t                 state;
  logic [CW-1:0]          count;
  logic                   pressed;

  // Metastability chain; only the last flop feeds the filter.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn_in};
    end
  end

  assign sync    = sync_q[SYNC_STAGES-1];
  assign differs = (sync != (state == ST_PRESSED));

  // Stability window and debounced state. Any agreeing cycle restarts the window.
  // The count is cleared when it reaches LAST, so it never wraps.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state   <= ST_RELEASED;
      count   <= '0;
      pressed <= 1'b0;
    end else begin
      pressed <= 1'b0;
      if (!differs) begin
        count <= '0;
      end else if (count == LAST) begin
        count <= '0;
        case (state)
          ST_RELEASED: begin
            state   <= ST_PRESSED;
            pressed <= 1'b1;
          end
          ST_PRESSED: begin
            state <= ST_RELEASED;
          end
          default: begin
            state <= ST_RELEASED;
          end
        endcase
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  assign bus.btn_pressed = pressed;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce.
// Dut a uses an 8-cycle window with 2 synchronizer stages.
// Dut b uses a 1-cycle window with 3 synchronizer stages.
// Each press pushes the cycle number at which its pulse is expected.
// The monitors pop that cycle number when btn_pressed is seen, sampling on the falling edge.
module tb_button_debounce;

  localparam int S_A    = 8;
  localparam int SYNC_A = 2;
  localparam int S_B    = 1;
  localparam int SYNC_B = 3;
  localparam int LAT_A  = S_A + SYNC_A;
  localparam int LAT_B  = S_B + SYNC_B;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   exp_a[$];
  int   exp_b[$];

  button_debounce_if bus_a ();
  button_debounce_if bus_b ();

  button_debounce #(.STABLE_CYCLES(S_A), .SYNC_STAGES(SYNC_A)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  button_debounce #(.STABLE_CYCLES(S_B), .SYNC_STAGES(SYNC_B)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_bit(input string name, input logic actual, input logic required);
    checks++;
    if (actual === required) passes++;
    else $display("FAIL %s: got %b required %b at cycle %0d", name, actual, required, cyc);
  endtask

  // Monitor for dut a: every pulse must match the oldest expected cycle.
  always @(negedge clk) begin
    if (bus_a.btn_pressed !== 1'b0) begin
      checks++;
      if (exp_a.size() == 0) begin
        $display("FAIL pulse_a: unexpected pulse (value %b) at cycle %0d, required none", bus_a.btn_pressed, cyc);
      end else begin
        int e;
        e = exp_a.pop_front();
        if (e == cyc && bus_a.btn_pressed === 1'b1) passes++;
        else $display("FAIL pulse_a: pulse at cycle %0d, required cycle %0d", cyc, e);
      end
    end
  end

  // Monitor for dut b: every pulse must match the oldest expected cycle.
  always @(negedge clk) begin
    if (bus_b.btn_pressed !== 1'b0) begin
      checks++;
      if (exp_b.size() == 0) begin
        $display("FAIL pulse_b: unexpected pulse (value %b) at cycle %0d, required none", bus_b.btn_pressed, cyc);
      end else begin
        int e;
        e = exp_b.pop_front();
        if (e == cyc && bus_b.btn_pressed === 1'b1) passes++;
        else $display("FAIL pulse_b: pulse at cycle %0d, required cycle %0d", cyc, e);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n        = 1'b1;
    bus_a.btn_in = 1'b0;
    bus_b.btn_in = 1'b0;

    // Reset held, then released with the button idle.
    wait_cycles(2);
    check_bit("reset_a", bus_a.btn_pressed, 1'b0);
    check_bit("reset_b", bus_b.btn_pressed, 1'b0);
    rst_n = 1'b0;
    wait_cycles(10);

    // Bouncy press with sub-cycle segments. The stable 1 is first sampled three edges later.
    begin
      int c0;
      c0 = cyc;
      exp_a.push_back(c0 + 3 + LAT_A);
      bus_a.btn_in = 1'b1; #7;
      bus_a.btn_in = 1'b0; #6;
      bus_a.btn_in = 1'b1; #8;
      bus_a.btn_in = 1'b0; #5;
      bus_a.btn_in = 1'b1;
    end
    wait_cycles(40);

    // Bouncy release, then stable low. No pulse is expected.
    bus_a.btn_in = 1'b0; #6;
    bus_a.btn_in = 1'b1; #7;
    bus_a.btn_in = 1'b0; #5;
    bus_a.btn_in = 1'b1; #9;
    bus_a.btn_in = 1'b0;
    wait_cycles(30);

    // Three short presses: 15 cycles high, then 15 cycles low.
    for (int i = 0; i < 3; i++) begin
      exp_a.push_back(cyc + LAT_A);
      bus_a.btn_in = 1'b1;
      wait_cycles(15);
      bus_a.btn_in = 1'b0;
      wait_cycles(15);
    end

    // Glitch: a dip of one cycle inside a window of 15 cycles restarts the count.
    bus_a.btn_in = 1'b1;
    wait_cycles(7);
    bus_a.btn_in = 1'b0;
    wait_cycles(1);
    bus_a.btn_in = 1'b1;
    wait_cycles(7);
    bus_a.btn_in = 1'b0;
    wait_cycles(20);

    // Reset during hold: a fresh pulse follows the reset release.
    exp_a.push_back(cyc + LAT_A);
    bus_a.btn_in = 1'b1;
    wait_cycles(14);
    rst_n = 1'b1;
    wait_cycles(3);
    rst_n = 1'b0;
    exp_a.push_back(cyc + LAT_A);
    wait_cycles(15);
    bus_a.btn_in = 1'b0;
    wait_cycles(15);

    // Asynchronous reset in mid-cycle drops a pulse that is already high.
    begin
      int c0;
      c0 = cyc;
      bus_a.btn_in = 1'b1;
      while (cyc < c0 + LAT_A - 1) @(negedge clk);
      @(posedge clk);
      #2;
      check_bit("pulse_before_async_reset", bus_a.btn_pressed, 1'b1);
      rst_n = 1'b1;
      #1;
      check_bit("pulse_after_async_reset", bus_a.btn_pressed, 1'b0);
    end

    // Reset held while the button is held and toggled: no pulse is expected.
    wait_cycles(12);
    bus_a.btn_in = 1'b0;
    wait_cycles(3);
    bus_a.btn_in = 1'b1;
    wait_cycles(12);
    bus_a.btn_in = 1'b0;
    rst_n = 1'b0;
    wait_cycles(15);

    // One-cycle window: a held press, then a press only one cycle long.
    exp_b.push_back(cyc + LAT_B);
    bus_b.btn_in = 1'b1;
    wait_cycles(6);
    bus_b.btn_in = 1'b0;
    wait_cycles(6);
    exp_b.push_back(cyc + LAT_B);
    bus_b.btn_in = 1'b1;
    wait_cycles(1);
    bus_b.btn_in = 1'b0;
    wait_cycles(10);

    // Every expected pulse must have been consumed.
    checks++;
    if (exp_a.size() == 0) passes++;
    else $display("FAIL missed_a: %0d pulses outstanding, required 0 (next at cycle %0d)", exp_a.size(), exp_a[0]);
    checks++;
    if (exp_b.size() == 0) passes++;
    else $display("FAIL missed_b: %0d pulses outstanding, required 0 (next at cycle %0d)", exp_b.size(), exp_b[0]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
